// File: rtl/expect_stim_gen.sv
// ---------------------------------------------------------------------------
// expect_stim_gen
//   Self-checking stimulus driver for a downstream clocked a==b checker.
//   Each run has vec_count vectors. For every vector the module:
//     - presents an operand pair on a_out/b_out,
//     - strobes ctrl_out for one cycle,
//     - waits up to TIMEOUT cycles for the checker's verdict,
//     - scores that verdict against the expected outcome.
//   Vectors chosen by err_every get a deliberate mismatch (b = a ^ 1).
//
// Handshake: ctrl_out is a one-cycle arm strobe and has no back-pressure.
//   The checker answers with a one-cycle resp_valid pulse that carries
//   resp_pass. A pulse counts only while the FSM is in WAIT, i.e. from the
//   cycle after the strobe up to and including the TIMEOUT-th cycle.
//   Pulses at any other time are dropped.
//
// Parameters
//   DW       operand width
//   TIMEOUT  max WAIT cycles per vector (>=1)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             begin a run (sampled only when idle)
//   vec_count         vectors per run; 0 means start is ignored
//   seed              base operand value (a_out = seed + vector index)
//   err_every         inject a mismatch on every Nth vector; 0 = never
//   resp_valid/pass   verdict pulse from the checker
//   a_out, b_out      operand pair
//   ctrl_out          arm strobe
//   busy, done        run in progress / one-cycle end-of-run pulse
//   pass_cnt, fail_cnt, mism_cnt, tmo_cnt
//                     saturating 16-bit result counters
//   dbg_state         current FSM state, for observation
//   aborted           only when EXPECT_STOP_ON_MISMATCH_EN is defined
//
// Build option: EXPECT_STOP_ON_MISMATCH_EN
//   When defined, the first unexpected verdict or timeout ends the run at once
//   and sets the sticky 'aborted' output.
// ---------------------------------------------------------------------------
module expect_stim_gen #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    vec_count,
  input  logic [DW-1:0] seed,
  input  logic [7:0]    err_every,
  input  logic          resp_valid,
  input  logic          resp_pass,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          ctrl_out,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pass_cnt,
  output logic [15:0]   fail_cnt,
  output logic [15:0]   mism_cnt,
  output logic [15:0]   tmo_cnt,
  output logic [2:0]    dbg_state
`ifdef EXPECT_STOP_ON_MISMATCH_EN
  ,
  output logic          aborted
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRIVE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    vcnt_q, vcnt_d;
  logic [7:0]    ev_q, ev_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    dn_q, dn_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          exp_q, exp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   pass_q, pass_d;
  logic [15:0]   fail_q, fail_d;
  logic [15:0]   mism_q, mism_d;
  logic [15:0]   tmo_q, tmo_d;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
  logic          aborted_q, aborted_d;
  logic          bad;
`endif

  logic load_en;
  logic vec_end;
  logic inj;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    ev_d    = ev_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    dn_d    = dn_q;
    a_d     = a_q;
    b_d     = b_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    mism_d  = mism_q;
    tmo_d   = tmo_q;
    load_en = 1'b0;
    vec_end = 1'b0;
    inj     = 1'b0;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
    aborted_d = aborted_q;
    bad       = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && (vec_count != 8'd0)) begin
          state_d = S_LOAD;
          vcnt_d  = vec_count;
          ev_d    = err_every;
          seed_d  = seed;
          idx_d   = 8'd0;
          dn_d    = err_every;
          pass_d  = 16'd0;
          fail_d  = 16'd0;
          mism_d  = 16'd0;
          tmo_d   = 16'd0;
          load_en = 1'b1;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_LOAD: state_d = S_DRIVE;
      S_DRIVE: begin
        state_d = S_WAIT;
        timer_d = TW'(1);
      end
      S_WAIT: begin
        // A verdict on the last allowed cycle takes priority over the timeout.
        if (resp_valid) begin
          vec_end = 1'b1;
          if (resp_pass) pass_d = sat_inc(pass_q);
          else           fail_d = sat_inc(fail_q);
          if (resp_pass != exp_q) begin
            mism_d = sat_inc(mism_q);
`ifdef EXPECT_STOP_ON_MISMATCH_EN
            bad = 1'b1;
`endif
          end
        end else if (timer_q == TW'(TIMEOUT)) begin
          vec_end = 1'b1;
          tmo_d   = sat_inc(tmo_q);
`ifdef EXPECT_STOP_ON_MISMATCH_EN
          bad = 1'b1;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end

        if (vec_end) begin
          if ((idx_q + 8'd1) == vcnt_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + 8'd1;
            load_en = 1'b1;
          end
`ifdef EXPECT_STOP_ON_MISMATCH_EN
          if (bad) begin
            state_d   = S_FIN;
            idx_d     = idx_q;
            load_en   = 1'b0;
            aborted_d = 1'b1;
          end
`endif
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The operands are computed on entry to LOAD, so they are already valid
    // during the LOAD cycle. They stay unchanged until the next entry.
    // The injection down-counter reloads when it fires, so every
    // err_every-th vector carries the mismatch.
    if (load_en) begin
      inj   = (ev_d != 8'd0) && (dn_d == 8'd1);
      a_d   = seed_d + DW'(idx_d);
      b_d   = inj ? (a_d ^ DW'(1)) : a_d;
      exp_d = ~inj;
      dn_d  = inj ? ev_d : (dn_d - 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vcnt_q  <= '0;
      ev_q    <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      dn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= 1'b0;
      timer_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      mism_q  <= '0;
      tmo_q   <= '0;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vcnt_q  <= vcnt_d;
      ev_q    <= ev_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      dn_q    <= dn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      mism_q  <= mism_d;
      tmo_q   <= tmo_d;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign ctrl_out  = (state_q == S_DRIVE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign mism_cnt  = mism_q;
  assign tmo_cnt   = tmo_q;
  assign dbg_state = state_q;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_expect_stim_gen.sv
module tb_expect_stim_gen;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    vec_count = '0;
  logic [DW-1:0] seed = '0;
  logic [7:0]    err_every = '0;
  logic          resp_valid = 1'b0;
  logic          resp_pass = 1'b0;
  logic [DW-1:0] a_out, b_out;
  logic          ctrl_out, busy, done;
  logic [15:0]   pass_cnt, fail_cnt, mism_cnt, tmo_cnt;
  logic [2:0]    dbg_state;
`ifdef EXPECT_STOP_ON_MISMATCH_EN
  logic          aborted;
`endif

  expect_stim_gen #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .seed(seed),
    .err_every(err_every), .resp_valid(resp_valid), .resp_pass(resp_pass),
    .a_out(a_out), .b_out(b_out), .ctrl_out(ctrl_out), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mism_cnt(mism_cnt), .tmo_cnt(tmo_cnt),
    .dbg_state(dbg_state)
`ifdef EXPECT_STOP_ON_MISMATCH_EN
    , .aborted(aborted)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2*DW-1:0] exp_q[$];     // expected {a,b} per strobe
  int              exp_cyc_q[$]; // expected strobe cycle (0 = first LOAD cycle)

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver: one full run against the reference model ----------------
  // pmode: 0 ideal checker (compares what it sees), 1 forced pass, 2 random verdict
  // dmode: 0 immediate verdict, 1 random delay or silence, 2 always silent
  task automatic do_run(input string name, input logic [DW-1:0] sd, input int n,
                        input int ev, input int pmode, input int dmode);
    int d[256];
    bit rv[256];
    int e_pass, e_fail, e_mism, e_tmo, t, cyc, v, k, budget;
    bit e_abort, got_done, active, ideal;
    logic [DW-1:0] ea;
    e_pass = 0; e_fail = 0; e_mism = 0; e_tmo = 0; t = 0; e_abort = 0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int i = 0; i < n; i++) begin
      if (dmode == 0)      d[i] = 1;
      else if (dmode == 2) d[i] = 0;
      else d[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      rv[i] = 1'($urandom_range(0, 1));
    end
    // Reference model: vector i has a = seed+i, and it is a mismatch when
    // (i+1) is a multiple of err_every.
    for (int i = 0; i < n; i++) begin
      bit inj_i, resp, bad;
      inj_i = (ev != 0) && (((i + 1) % ev) == 0);
      ea    = sd + DW'(i);
      exp_q.push_back({ea, inj_i ? (ea ^ DW'(1)) : ea});
      exp_cyc_q.push_back(t + 1);
      if (d[i] == 0) begin
        e_tmo++; bad = 1'b1; t += 2 + TIMEOUT;
      end else begin
        resp = (pmode == 0) ? !inj_i : (pmode == 1) ? 1'b1 : rv[i];
        if (resp) e_pass++; else e_fail++;
        bad = (resp == inj_i);
        if (bad) e_mism++;
        t += 2 + d[i];
      end
`ifdef EXPECT_STOP_ON_MISMATCH_EN
      if (bad) begin e_abort = 1'b1; break; end
`endif
    end

    @(negedge clk);
    start = 1'b1; vec_count = 8'(n); seed = sd; err_every = 8'(ev); resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; vec_count = 8'($urandom); seed = $urandom; err_every = 8'($urandom);
    cyc = 0; v = -1; k = 0; active = 1'b0; ideal = 1'b0; got_done = 1'b0;
    budget = t + 30;
    while (!got_done && cyc < budget) begin
      resp_valid = 1'b0;
      resp_pass  = 1'($urandom);
      if (ctrl_out) begin
        v++;
        if (exp_q.size() == 0) begin
          check_eq({name, " extra_strobe"}, 1, 0);
          active = 1'b0;
        end else begin
          check_eq({name, " ab"}, {a_out, b_out}, exp_q.pop_front());
          check_eq({name, " strobe_cyc"}, cyc, exp_cyc_q.pop_front());
          ideal  = (a_out == b_out);
          active = 1'b1;
          k      = 0;
        end
        if ($urandom_range(0, 3) == 0) resp_valid = 1'b1; // must be ignored in DRIVE
      end else if (active) begin
        k++;
        if (d[v] != 0 && k == d[v]) begin
          resp_valid = 1'b1;
          resp_pass  = (pmode == 0) ? ideal : (pmode == 1) ? 1'b1 : rv[v];
          active     = 1'b0;
        end else if (k >= TIMEOUT) begin
          active = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        resp_valid = 1'b1; // outside WAIT, must be ignored
      end
      if (done) got_done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    resp_valid = 1'b0;
    if (!got_done) check_eq({name, " done_timeout"}, 0, 1);
    check_eq({name, " done_cyc"}, cyc, t);
    check_eq({name, " missing_strobes"}, exp_q.size(), 0);
    check_eq({name, " pass_cnt"}, pass_cnt, e_pass);
    check_eq({name, " fail_cnt"}, fail_cnt, e_fail);
    check_eq({name, " mism_cnt"}, mism_cnt, e_mism);
    check_eq({name, " tmo_cnt"}, tmo_cnt, e_tmo);
`ifdef EXPECT_STOP_ON_MISMATCH_EN
    check_eq({name, " aborted"}, aborted, e_abort);
`else
    check_eq({name, " no_abort"}, e_abort, 0);
`endif
    @(negedge clk);
    check_eq({name, " busy_after"}, {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    check_eq({name, " cnt_hold"}, {pass_cnt, fail_cnt, mism_cnt, tmo_cnt},
             {16'(e_pass), 16'(e_fail), 16'(e_mism), 16'(e_tmo)});
  endtask

  // Reset in the WAIT of vector 1, then a start with vec_count=0.
  task automatic reset_mid_run();
    int strobes, cyc;
    bit saw;
    @(negedge clk);
    start = 1'b1; vec_count = 8'd3; seed = $urandom; err_every = 8'd0; resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    strobes = 0; cyc = 0;
    while (strobes < 2 && cyc < 100) begin
      if (ctrl_out) strobes++;
      if (strobes < 2) begin @(negedge clk); cyc++; end
    end
    check_eq("rst_reach_vec1", strobes, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_outputs", {a_out, b_out, ctrl_out, busy, done, pass_cnt, fail_cnt, mism_cnt, tmo_cnt}, '0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (2 * TIMEOUT) begin
      @(negedge clk);
      if (done || busy || ctrl_out) saw = 1'b1;
    end
    check_eq("rst_no_done", saw, 0);
    start = 1'b1; vec_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      if (busy || ctrl_out) saw = 1'b1;
      @(negedge clk);
    end
    check_eq("vec0_ignored", saw, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {a_out, b_out, ctrl_out, busy, done, pass_cnt, fail_cnt, mism_cnt, tmo_cnt}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_run("t1_basic",  32'd5,         3, 0, 0, 0);
    do_run("t2_inject", 32'd0,         4, 2, 0, 0);
    do_run("t3_tmo",    $urandom,      2, 0, 0, 2);
    do_run("t4_forced", $urandom,      3, 1, 1, 0);
    do_run("t5_wrap",   32'hFFFF_FFFF, 2, 0, 0, 0);
    reset_mid_run();
    for (int r = 0; r < 8; r++) begin
      do_run("rand", $urandom, int'($urandom_range(1, 12)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 2)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
